// File: rtl/gen_reduce_if.sv
// Generator-protocol bundle around gen_reduce: the caller-facing
// start/ready/valid/done/result signals and the child-facing launch/drain
// signals. The slave modport is the reducer's view; master is its environment.
interface gen_reduce_if #(
    parameter int WIDTH = 32
);
    // Caller side
    logic                    _start;
    logic signed [WIDTH-1:0] n;
    logic                    _ready;
    logic                    _valid;
    logic                    _done;
    logic signed [WIDTH-1:0] _out0;
    logic signed [WIDTH-1:0] _out1;
    logic [31:0]             _out2;

    // Child side
    logic                    _child_start;
    logic signed [WIDTH-1:0] _child_n;
    logic                    _child_ready;
    logic                    _child_valid;
    logic                    _child_done;
    logic signed [WIDTH-1:0] _child_out0;
    logic signed [WIDTH-1:0] _child_out1;

    modport slave (
        input  _start, n, _ready,
        input  _child_valid, _child_done, _child_out0, _child_out1,
        output _valid, _done, _out0, _out1, _out2,
        output _child_start, _child_n, _child_ready
    );

    modport master (
        output _start, n, _ready,
        output _child_valid, _child_done, _child_out0, _child_out1,
        input  _valid, _done, _out0, _out1, _out2,
        input  _child_start, _child_n, _child_ready
    );
endinterface

// File: rtl/gen_reduce.sv
// gen_reduce: launches one child generator, drains its (out0, out1) tuple
// stream into a wrapped sum, a signed max and a saturating count, then
// offers the three results to its own caller as a single-tuple generator.
module gen_reduce #(
    parameter int WIDTH = 32
) (
    input  logic        _clock,
    input  logic        _reset,
    gen_reduce_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        DRAIN,
        EMIT
    } state_t;

    // Most negative WIDTH-bit value: the identity element for signed max.
    localparam logic signed [WIDTH-1:0] MAX_INIT = {1'b1, {(WIDTH-1){1'b0}}};

    state_t                  state;
    logic signed [WIDTH-1:0] sum;
    logic signed [WIDTH-1:0] max_val;
    logic [31:0]             count;

    logic                    accept;
    logic signed [WIDTH-1:0] max_next;
    logic [31:0]             count_next;

    // Tuple-accept qualifier and the candidate max/count for the tuple on offer.
    always_comb begin
        // NOTE: every always_comb output is given a default first, so no path
        // through the block can leave it unassigned and infer a latch.
        accept     = (state == DRAIN) && bus._child_ready && bus._child_valid;
        max_next   = max_val;
        count_next = count;
        if ($signed(bus._child_out1) > $signed(max_val)) begin
            max_next = bus._child_out1;
        end
        if (count != 32'hFFFF_FFFF) begin
            count_next = count + 32'd1;
        end
    end

    // Run-control FSM with all outputs registered; start outranks reset.
    always_ff @(posedge _clock) begin
        // NOTE: state and registered outputs use non-blocking assignments so
        // every read in this block sees the pre-edge value, like real flops.
        bus._done <= 1'b0;

        if (bus._start) begin
            // Begin (or abort and restart) a run: the child start pulse and
            // parameter go out on this edge so the child sees them next edge.
            sum              <= '0;
            max_val          <= MAX_INIT;
            count            <= '0;
            bus._valid       <= 1'b0;
            bus._child_start <= 1'b1;
            bus._child_n     <= bus.n;
            bus._child_ready <= 1'b0;
            state            <= LAUNCH;
        end else if (_reset) begin
            sum              <= '0;
            max_val          <= MAX_INIT;
            count            <= '0;
            bus._valid       <= 1'b0;
            bus._out0        <= '0;
            bus._out1        <= '0;
            bus._out2        <= '0;
            bus._child_start <= 1'b0;
            bus._child_n     <= '0;
            bus._child_ready <= 1'b0;
            state            <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    bus._child_start <= 1'b0;
                    bus._child_ready <= 1'b0;
                end

                LAUNCH: begin
                    // The child samples its start on this edge; it cannot have
                    // produced anything yet, so nothing is sampled here.
                    bus._child_start <= 1'b0;
                    bus._child_ready <= 1'b1;
                    state            <= DRAIN;
                end

                DRAIN: begin
                    bus._child_start <= 1'b0;
                    bus._child_ready <= 1'b1;
                    // A tuple accepted on the done edge still counts.
                    if (accept) begin
                        sum     <= sum + bus._child_out0;
                        max_val <= max_next;
                        count   <= count_next;
                    end
                    if (bus._child_done) begin
                        bus._child_ready <= 1'b0;
                        state            <= EMIT;
                    end
                end

                EMIT: begin
                    if (!bus._valid) begin
                        bus._out0  <= sum;
                        bus._out1  <= max_val;
                        bus._out2  <= count;
                        bus._valid <= 1'b1;
                    end else if (bus._ready) begin
                        bus._valid <= 1'b0;
                        bus._done  <= 1'b1;
                        state      <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gen_reduce.sv
// Testbench for gen_reduce: a behavioural child generator replays a tuple
// list per launch; expected results are pushed when a run is launched and
// compared when the caller accepts the result tuple.
module tb_gen_reduce;

    localparam int WIDTH = 32;
    localparam logic signed [31:0] MAX_INIT = 32'sh8000_0000;

    typedef struct packed {
        logic signed [31:0] o0;
        logic signed [31:0] o1;
        logic [3:0]         gap;
    } tuple_t;

    typedef struct packed {
        logic signed [31:0] sum;
        logic signed [31:0] max;
        logic [31:0]        cnt;
    } result_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    gen_reduce_if #(.WIDTH(WIDTH)) bus ();

    gen_reduce #(.WIDTH(WIDTH)) dut (
        ._clock (clk),
        ._reset (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int      n_tests = 0;
    int      n_fail  = 0;
    tuple_t  pend_q[$];
    bit      done_with_last = 1'b0;
    result_t exp_q[$];

    int acc_cnt  = 0;
    int res_cnt  = 0;
    int done_cnt = 0;
    int cs_cnt   = 0;
    bit prev_accept = 1'b0;

    // ---------------- behavioural child generator ----------------
    tuple_t run_q[$];
    tuple_t popped;
    int     gap_cnt = 0;
    bit     running = 1'b0;

    // Child: reload tuple list on start, offer tuples with per-tuple gaps,
    // pulse done after the last tuple (or together with it).
    always @(posedge clk) begin
        if (rst) begin
            run_q.delete();
            running = 1'b0;
            bus._child_valid <= 1'b0;
            bus._child_done  <= 1'b0;
        end else if (bus._child_start) begin
            run_q   = pend_q;
            running = (run_q.size() != 0);
            gap_cnt = running ? int'(run_q[0].gap) : 0;
            bus._child_valid <= 1'b0;
            bus._child_done  <= !running;
        end else begin
            bus._child_done <= 1'b0;
            if (bus._child_valid && bus._child_ready && run_q.size() != 0) begin
                popped  = run_q.pop_front();
                gap_cnt = (run_q.size() != 0) ? int'(run_q[0].gap) : 0;
            end
            if (bus._child_valid && !bus._child_ready) begin
                // hold the offered tuple
            end else if (running) begin
                if (run_q.size() == 0) begin
                    bus._child_valid <= 1'b0;
                    running = 1'b0;
                    if (!done_with_last) bus._child_done <= 1'b1;
                end else if (gap_cnt > 0) begin
                    bus._child_valid <= 1'b0;
                    gap_cnt--;
                end else begin
                    bus._child_valid <= 1'b1;
                    bus._child_out0  <= run_q[0].o0;
                    bus._child_out1  <= run_q[0].o1;
                    if (done_with_last && run_q.size() == 1) bus._child_done <= 1'b1;
                end
            end
        end
    end

    // ---------------- caller-side monitor / scoreboard ----------------
    // Sample on the falling edge: count events, check done timing, score results.
    always @(negedge clk) begin
        result_t e;
        if (bus._child_valid === 1'b1 && bus._child_ready === 1'b1) acc_cnt++;
        if (bus._child_start === 1'b1) cs_cnt++;
        if (bus._done === 1'b1) done_cnt++;

        if (prev_accept || bus._done === 1'b1) begin
            n_tests++;
            if (bus._done !== prev_accept || bus._valid !== 1'b0) begin
                n_fail++;
                $display("FAIL done_timing: got done=%b valid=%b, required done=%b valid=0",
                         bus._done, bus._valid, prev_accept);
            end
        end

        prev_accept = (bus._valid === 1'b1) && (bus._ready === 1'b1);
        if (prev_accept) begin
            res_cnt++;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL result_unexpected: got %0d/%0d/%0d, required no result",
                         bus._out0, bus._out1, bus._out2);
            end else begin
                e = exp_q.pop_front();
                if (bus._out0 !== e.sum || bus._out1 !== e.max || bus._out2 !== e.cnt) begin
                    n_fail++;
                    $display("FAIL result: got %0d/%0d/%0d, required %0d/%0d/%0d",
                             bus._out0, bus._out1, bus._out2, e.sum, e.max, e.cnt);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_hrange(input int nv, input int gap_max);
        tuple_t t;
        pend_q.delete();
        for (int i = 0; i < nv; i++) begin
            t.o0  = 32'(i);
            t.o1  = 32'(i);
            t.gap = 4'($urandom_range(0, gap_max));
            pend_q.push_back(t);
        end
    endtask

    // Push the expected reduction of pend_q, then pulse _start for one edge.
    task automatic launch(input logic signed [31:0] nv, input bit with_reset);
        result_t e;
        e.sum = '0;
        e.max = MAX_INIT;
        e.cnt = '0;
        foreach (pend_q[i]) begin
            e.sum = e.sum + pend_q[i].o0;
            if ($signed(pend_q[i].o1) > $signed(e.max)) e.max = pend_q[i].o1;
            e.cnt = e.cnt + 32'd1;
        end
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus._start = 1'b1;
        bus.n      = nv;
        if (with_reset) rst = 1'b1;
        @(posedge clk); #1;
        bus._start = 1'b0;
        rst        = 1'b0;
    endtask

    // Bounded wait for the next _done pulse; an expired bound is a failure.
    task automatic wait_done(input int base, input string name);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done_cnt > base) break;
        end
        n_tests++;
        if (done_cnt <= base) begin
            n_fail++;
            $display("FAIL %s_timeout: got no _done in 300 cycles, required one", name);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (bus._valid !== 1'b0 || bus._done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid_done: got %b/%b, required 0/0", bus._valid, bus._done);
        end
        n_tests++;
        if (bus._child_start !== 1'b0 || bus._child_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_child_ctrl: got %b/%b, required 0/0",
                     bus._child_start, bus._child_ready);
        end
        n_tests++;
        if (bus._out0 !== '0 || bus._out1 !== '0 || bus._out2 !== '0 || bus._child_n !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %0d/%0d/%0d n=%0d, required 0/0/0 n=0",
                     bus._out0, bus._out1, bus._out2, bus._child_n);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_nominal();
        int b = done_cnt;
        int r = res_cnt;
        int c = cs_cnt;
        set_hrange(10, 0);
        launch(10, 1'b0);
        @(negedge clk);
        n_tests++;
        if (bus._child_start !== 1'b1 || bus._child_ready !== 1'b0 || bus._child_n !== 32'sd10) begin
            n_fail++;
            $display("FAIL launch_cycle: got start=%b ready=%b n=%0d, required 1/0/10",
                     bus._child_start, bus._child_ready, bus._child_n);
        end
        @(negedge clk);
        n_tests++;
        if (bus._child_start !== 1'b0 || bus._child_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_entry: got start=%b ready=%b, required 0/1",
                     bus._child_start, bus._child_ready);
        end
        wait_done(b, "nominal");
        n_tests++;
        if (cs_cnt - c !== 1 || res_cnt - r !== 1) begin
            n_fail++;
            $display("FAIL nominal_counts: got child_start cycles=%0d results=%0d, required 1/1",
                     cs_cnt - c, res_cnt - r);
        end
    endtask

    task automatic test_empty();
        logic signed [31:0] nlist [2];
        nlist[0] = 32'sd0;
        nlist[1] = -32'sd5;
        for (int t = 0; t < 2; t++) begin
            int b = done_cnt;
            int k;
            pend_q.delete();
            launch(nlist[t], 1'b0);
            for (k = 1; k < 50; k++) begin
                @(negedge clk);
                if (bus._valid === 1'b1) break;
            end
            n_tests++;
            if (k != 4) begin
                n_fail++;
                $display("FAIL empty_latency: got valid at cycle %0d for n=%0d, required 4",
                         k, nlist[t]);
            end
            wait_done(b, "empty");
        end
    endtask

    task automatic test_backpressure_wrap();
        tuple_t t;
        logic signed [31:0] c0, c1;
        logic [31:0] c2;
        int b = done_cnt;
        int k;
        pend_q.delete();
        t.o0 = 32'sh7FFF_FFFF; t.o1 = -32'sd7; t.gap = 4'd0; pend_q.push_back(t);
        t.o0 = 32'sh7FFF_FFFF; t.o1 = 32'sd5;  t.gap = 4'd1; pend_q.push_back(t);
        bus._ready = 1'b0;
        launch(2, 1'b0);
        for (k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (bus._valid === 1'b1) break;
        end
        c0 = bus._out0; c1 = bus._out1; c2 = bus._out2;
        n_tests++;
        if (c0 !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("FAIL wrap_sum: got %h, required fffffffe", c0);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (bus._valid !== 1'b1 || bus._done !== 1'b0 ||
                bus._out0 !== c0 || bus._out1 !== c1 || bus._out2 !== c2) begin
                n_fail++;
                $display("FAIL backpressure_hold: got valid=%b done=%b %0d/%0d/%0d, required 1/0 %0d/%0d/%0d",
                         bus._valid, bus._done, bus._out0, bus._out1, bus._out2, c0, c1, c2);
            end
        end
        bus._ready = 1'b1;
        wait_done(b, "backpressure");
    endtask

    task automatic test_child_stalls();
        tuple_t t;
        logic [3:0] gaps [4];
        int b = done_cnt;
        int r = res_cnt;
        gaps[0] = 4'd2; gaps[1] = 4'd0; gaps[2] = 4'd3; gaps[3] = 4'd1;
        pend_q.delete();
        for (int i = 0; i < 4; i++) begin
            t.o0 = 32'(i); t.o1 = 32'(i); t.gap = gaps[i];
            pend_q.push_back(t);
        end
        done_with_last = 1'b1;
        launch(4, 1'b0);
        wait_done(b, "stalls");
        done_with_last = 1'b0;
        n_tests++;
        if (res_cnt - r !== 1) begin
            n_fail++;
            $display("FAIL stalls_results: got %0d results, required 1", res_cnt - r);
        end
    endtask

    task automatic test_reset_mid();
        int b = done_cnt;
        int a0 = acc_cnt;
        set_hrange(10, 0);
        launch(10, 1'b0);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (acc_cnt >= a0 + 3) break;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_tests++;
        if (bus._valid !== 1'b0 || bus._child_ready !== 1'b0 || bus._child_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_ctrl: got valid=%b ready=%b start=%b, required 0/0/0",
                     bus._valid, bus._child_ready, bus._child_start);
        end
        exp_q.delete();
        repeat (20) @(negedge clk);
        n_tests++;
        if (done_cnt !== b) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: got %0d done pulses, required 0", done_cnt - b);
        end
        set_hrange(4, 0);
        launch(4, 1'b0);
        wait_done(b, "after_reset");
    endtask

    task automatic test_collision();
        int b = done_cnt;
        set_hrange(3, 0);
        launch(3, 1'b1);
        wait_done(b, "collision");
    endtask

    task automatic test_restart();
        int a0 = acc_cnt;
        int r;
        int b;
        set_hrange(10, 1);
        launch(10, 1'b0);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (acc_cnt >= a0 + 3) break;
        end
        exp_q.delete();
        r = res_cnt;
        b = done_cnt;
        set_hrange(2, 0);
        launch(2, 1'b0);
        wait_done(b, "restart");
        n_tests++;
        if (res_cnt - r !== 1 || done_cnt - b !== 1) begin
            n_fail++;
            $display("FAIL restart_counts: got results=%0d dones=%0d, required 1/1",
                     res_cnt - r, done_cnt - b);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            int b = done_cnt;
            int nv = int'($urandom_range(1, 8));
            set_hrange(nv, 2);
            launch(nv, 1'b0);
            wait_done(b, "back_to_back");
        end
    endtask

    // Watchdog: a hung run still reports before stopping.
    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus._start = 1'b0;
        bus.n      = '0;
        bus._ready = 1'b1;
        test_reset();
        test_nominal();
        test_empty();
        test_backpressure_wrap();
        test_child_stalls();
        test_reset_mid();
        test_collision();
        test_restart();
        test_back_to_back();
        repeat (5) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_results: got %0d unconsumed, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
